// File: rtl/usb_protocol_ctrl.sv
// USB device-side protocol controller: sequences OUT/IN token handling,
// handshake transmission, FIFO ownership and error/timeout reporting.
module usb_protocol_ctrl #(
  parameter int unsigned TIMEOUT = 800
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] rx_packet,
  input  logic       rx_data_ready,
  input  logic       rx_error,
  input  logic       tx_done,
  input  logic       tx_error,
  input  logic       tx_data_pending,
  input  logic [6:0] buffer_occupancy,
  output logic       tx_start,
  output logic [1:0] tx_packet,
  output logic       d_mode,
  output logic       buffer_clear,
  output logic       proto_err,
  output logic       timeout_err,
  output logic       ctrl_busy
);

  localparam logic [2:0]  PID_NONE = 3'd0;
  localparam logic [2:0]  PID_OUT  = 3'd1;
  localparam logic [2:0]  PID_IN   = 3'd2;
  localparam logic [2:0]  PID_DATA = 3'd3;
  localparam logic [2:0]  PID_ACK  = 3'd4;
  localparam logic [2:0]  PID_NAK  = 3'd5;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, OUT_WAIT, SEND_ACK, SEND_NAK, ACK_BUSY,
    IN_DATA, IN_BUSY, IN_WAIT_ACK, CLEAR, ERR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic        nak_q, nak_nxt;
  logic        tmo_q, tmo_nxt;
  logic        waiting, expired;

  assign waiting = (state == OUT_WAIT) || (state == ACK_BUSY) ||
                   (state == IN_BUSY)  || (state == IN_WAIT_ACK);
  assign expired = waiting && (timer == TMO_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      timer <= '0;
      nak_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      nak_q <= nak_nxt;
      tmo_q <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    nak_nxt   = nak_q;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_data_ready && rx_packet == PID_OUT) begin
          state_nxt = OUT_WAIT;
        end else if (rx_data_ready && rx_packet == PID_IN) begin
          if (tx_data_pending && buffer_occupancy != 7'd0) state_nxt = IN_DATA;
          else                                             state_nxt = SEND_NAK;
        end
      end
      OUT_WAIT: begin
        if (rx_data_ready && rx_packet == PID_DATA)      state_nxt = SEND_ACK;
        else if (rx_data_ready && rx_packet != PID_NONE) state_nxt = ERR;
        else if (expired) begin
          state_nxt = IDLE;
          tmo_nxt   = 1'b1;
        end
      end
      SEND_ACK: begin
        nak_nxt   = 1'b0;
        state_nxt = ACK_BUSY;
      end
      SEND_NAK: begin
        nak_nxt   = 1'b1;
        state_nxt = ACK_BUSY;
      end
      ACK_BUSY: begin
        if (tx_done)      state_nxt = IDLE;
        else if (expired) state_nxt = ERR;
      end
      IN_DATA: state_nxt = IN_BUSY;
      IN_BUSY: begin
        if (tx_done)      state_nxt = IN_WAIT_ACK;
        else if (expired) state_nxt = ERR;
      end
      IN_WAIT_ACK: begin
        // A NAK or silence leaves the payload in the FIFO for the host's retry
        if (rx_data_ready && rx_packet == PID_ACK)      state_nxt = CLEAR;
        else if (rx_data_ready && rx_packet == PID_NAK) state_nxt = IDLE;
        else if (expired) begin
          state_nxt = IDLE;
          tmo_nxt   = 1'b1;
        end
      end
      CLEAR:   state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE && (rx_error || tx_error)) begin
      state_nxt = ERR;
      tmo_nxt   = 1'b0;
    end

    if (state_nxt != state) timer_nxt = '0;
    else if (waiting)       timer_nxt = timer + 16'd1;
    else                    timer_nxt = timer;
  end

  always_comb begin
    tx_start     = 1'b0;
    tx_packet    = 2'd0;
    d_mode       = 1'b0;
    buffer_clear = 1'b0;
    proto_err    = 1'b0;
    timeout_err  = tmo_q;
    ctrl_busy    = (state != IDLE);
    case (state)
      SEND_ACK: begin
        tx_start  = 1'b1;
        tx_packet = 2'd2;
      end
      SEND_NAK: begin
        tx_start  = 1'b1;
        tx_packet = 2'd3;
      end
      ACK_BUSY: tx_packet = nak_q ? 2'd3 : 2'd2;
      IN_DATA: begin
        tx_start  = 1'b1;
        tx_packet = 2'd1;
        d_mode    = 1'b1;
      end
      IN_BUSY: begin
        tx_packet = 2'd1;
        d_mode    = 1'b1;
      end
      IN_WAIT_ACK: d_mode = 1'b1;
      CLEAR:       buffer_clear = 1'b1;
      ERR: begin
        proto_err    = 1'b1;
        buffer_clear = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/usb_protocol_ctrl.md
USB_PROTOCOL_CTRL -- requirements
Module: usb_protocol_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 800, meaning cycles allowed in a wait state before timeout (1..65535).
REQ-002 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst  in  1  reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rx_packet  in  3  decoded RX PID: 0 none, 1 OUT, 2 IN, 3 DATA0/1, 4 ACK, 5 NAK; valid only with rx_data_ready.
REQ-005 SHALL have port rx_data_ready  in  1  one-cycle pulse, rx_packet valid.
REQ-006 SHALL have port rx_error  in  1  receiver error (PID/EOP/overflow), one-cycle pulse.
REQ-007 SHALL have port tx_done  in  1  one-cycle pulse, transmitter finished current packet.
REQ-008 SHALL have port tx_error  in  1  transmitter error, one-cycle pulse.
REQ-009 SHALL have port tx_data_pending  in  1  AHB side has loaded an IN payload.
REQ-010 SHALL have port buffer_occupancy  in  7  shared FIFO byte count (0..64).
REQ-011 SHALL have port tx_start  out  1  one-cycle request to transmitter.
REQ-012 SHALL have port tx_packet  out  2  packet to send: 0 none, 1 DATA, 2 ACK, 3 NAK; held from tx_start until tx_done.
REQ-013 SHALL have port d_mode  out  1  FIFO ownership: 0 RX writes, 1 TX reads.
REQ-014 SHALL have port buffer_clear  out  1  one-cycle FIFO flush.
REQ-015 SHALL have port proto_err  out  1  one-cycle protocol error flag.
REQ-016 SHALL have port timeout_err  out  1  one-cycle timeout flag.
REQ-017 SHALL have port ctrl_busy  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, OUT_WAIT, SEND_ACK, SEND_NAK, ACK_BUSY, IN_DATA, IN_BUSY, IN_WAIT_ACK, CLEAR, ERR; all outputs Moore-decoded from state register.
REQ-019 IDLE: rx_data_ready & rx_packet=OUT -> OUT_WAIT; rx_packet=IN & tx_data_pending & buffer_occupancy!=0 -> IN_DATA; rx_packet=IN otherwise -> SEND_NAK; any other PID ignored.
REQ-020 OUT_WAIT: rx_data_ready & rx_packet=DATA -> SEND_ACK; any other valid PID -> ERR; timeout -> IDLE with timeout_err pulse.
REQ-021 SEND_ACK / SEND_NAK: tx_start=1 for exactly the one cycle in state, tx_packet=2/3; -> ACK_BUSY unconditionally.
REQ-022 ACK_BUSY: tx_packet held; tx_done -> IDLE; timeout -> ERR.
REQ-023 IN_DATA: tx_start=1, tx_packet=1, d_mode=1 for one cycle; -> IN_BUSY.
REQ-024 IN_BUSY: d_mode=1, tx_packet=1; tx_done -> IN_WAIT_ACK; timeout -> ERR.
REQ-025 IN_WAIT_ACK: rx_packet=ACK -> CLEAR; rx_packet=NAK or timeout -> IDLE, payload retained for retry (no buffer_clear); timeout also pulses timeout_err.
REQ-026 CLEAR: buffer_clear=1 one cycle, d_mode=0; -> IDLE.
REQ-027 ERR: proto_err=1 and buffer_clear=1 one cycle; -> IDLE.
REQ-028 rx_error or tx_error in any non-IDLE state SHALL force -> ERR, taking priority over every other same-cycle event; both ignored in IDLE.
REQ-029 Latency: event sampled at edge N -> new state and its outputs valid after edge N, i.e. tx_start one cycle after rx_data_ready.
REQ-030 Timer: 16-bit, cleared on every state change, increments each cycle in OUT_WAIT/ACK_BUSY/IN_BUSY/IN_WAIT_ACK; timeout when count = TIMEOUT-1 with no exiting event; exiting event wins over timeout in same cycle.
REQ-031 d_mode SHALL be 1 only in IN_DATA, IN_BUSY, IN_WAIT_ACK; buffer_occupancy=64 is treated as non-empty.

Reset
REQ-032 n_rst low SHALL immediately force IDLE, timer=0, all outputs 0, regardless of clock or in-flight transfer.
REQ-033 After n_rst release, first transition SHALL be evaluated at the next rising clk.

Verification
REQ-034 OUT then DATA pulses, then tx_done 5 cycles later -> tx_start one cycle after DATA with tx_packet=2; IDLE after tx_done; no errors.
REQ-035 IN with tx_data_pending=1, occupancy=8 -> tx_start, tx_packet=1, d_mode=1; tx_done then ACK -> buffer_clear one cycle, d_mode=0, IDLE.
REQ-036 IN with tx_data_pending=0 -> SEND_NAK: tx_start, tx_packet=3; IDLE after tx_done.
REQ-037 TIMEOUT=10, OUT with no DATA -> timeout_err pulse exactly 10 cycles after OUT_WAIT entry, back to IDLE.
REQ-038 rx_error and rx_data_ready(DATA) same cycle in OUT_WAIT -> ERR: proto_err and buffer_clear one cycle, no tx_start.
REQ-039 n_rst asserted mid IN_BUSY -> all outputs 0 asynchronously; IDLE after release.
